// File: rtl/seed_exchange_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seed_exchange_if : local seed, peer seed and UART line signals           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+

interface seed_exchange_if;
  logic       seed_rdy;
  logic [4:0] seed_x_local;
  logic [4:0] seed_y_local;
  logic       uart_rx;
  logic       uart_tx;
  logic       tx_busy;
  logic [4:0] seed_x_peer;
  logic [4:0] seed_y_peer;
  logic       peer_valid;

  modport master (
    output seed_rdy, seed_x_local, seed_y_local, uart_rx,
    input  uart_tx, tx_busy, seed_x_peer, seed_y_peer, peer_valid
  );

  modport slave (
    input  seed_rdy, seed_x_local, seed_y_local, uart_rx,
    output uart_tx, tx_busy, seed_x_peer, seed_y_peer, peer_valid
  );
endinterface

`default_nettype wire

// File: rtl/seed_exchange.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seed_exchange : swaps 5-bit x/y seeds with a peer over a 2-byte UART frame|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+

module seed_exchange #(
  parameter int         BAUD_DIV = 651,
  parameter logic [2:0] TAG_X    = 3'b101,
  parameter logic [2:0] TAG_Y    = 3'b110
) (
  input  logic          clk_75,
  input  logic          rst,
  seed_exchange_if.slave bus
);

  localparam int             CNT_W     = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  tx_state_t        tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic             tx_sel;
  logic [4:0]       tx_x;
  logic [4:0]       tx_y;
  logic             uart_tx_q;
  logic             tx_busy_q;
  logic [7:0]       tx_byte;
  logic [2:0]       tx_bit_nxt;
  logic             tx_bit_end;

  assign tx_byte    = tx_sel ? {TAG_Y, tx_y} : {TAG_X, tx_x};
  assign tx_bit_nxt = tx_bit + 3'd1;
  assign tx_bit_end = (tx_cnt == BAUD_LAST);

  always_ff @(posedge clk_75) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= 3'd0;
      tx_sel    <= 1'b0;
      tx_x      <= 5'd0;
      tx_y      <= 5'd0;
      uart_tx_q <= 1'b1;
      tx_busy_q <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (bus.seed_rdy) begin
            tx_x      <= bus.seed_x_local;
            tx_y      <= bus.seed_y_local;
            tx_sel    <= 1'b0;
            tx_cnt    <= '0;
            uart_tx_q <= 1'b0;
            tx_busy_q <= 1'b1;
            tx_state  <= TX_START;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_cnt    <= '0;
            tx_bit    <= 3'd0;
            uart_tx_q <= tx_byte[0];
            tx_state  <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              uart_tx_q <= 1'b1;
              tx_state  <= TX_STOP;
            end else begin
              tx_bit    <= tx_bit_nxt;
              uart_tx_q <= tx_byte[tx_bit_nxt];
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        TX_STOP: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            // byte1 start bit follows byte0 stop bit with no idle gap
            if (!tx_sel) begin
              tx_sel    <= 1'b1;
              uart_tx_q <= 1'b0;
              tx_state  <= TX_START;
            end else begin
              tx_busy_q <= 1'b0;
              tx_state  <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign bus.uart_tx = uart_tx_q;
  assign bus.tx_busy = tx_busy_q;

  logic rx_s1;
  logic rx_s2;
  logic rx_prev;

  always_ff @(posedge clk_75) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= bus.uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             got_x;
  logic [4:0]       pend_x;
  logic [4:0]       peer_x_q;
  logic [4:0]       peer_y_q;
  logic             peer_valid_q;
  logic             rx_bit_end;

  assign rx_bit_end = (rx_cnt == BAUD_LAST);

  always_ff @(posedge clk_75) begin
    if (rst) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= 3'd0;
      rx_shift     <= 8'd0;
      got_x        <= 1'b0;
      pend_x       <= 5'd0;
      peer_x_q     <= 5'd0;
      peer_y_q     <= 5'd0;
      peer_valid_q <= 1'b0;
    end else begin
      peer_valid_q <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          // a framing error leaves rx_prev low, so the line must go high first
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            if (rx_s2) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_bit   <= 3'd0;
              rx_state <= RX_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (rx_bit_end) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (rx_bit_end) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (!rx_s2) begin
              got_x <= 1'b0;
            end else if (rx_shift[7:5] == TAG_X) begin
              pend_x <= rx_shift[4:0];
              got_x  <= 1'b1;
            end else if (rx_shift[7:5] == TAG_Y) begin
              if (got_x) begin
                peer_x_q     <= pend_x;
                peer_y_q     <= rx_shift[4:0];
                peer_valid_q <= 1'b1;
                got_x        <= 1'b0;
              end
            end else begin
              got_x <= 1'b0;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign bus.seed_x_peer = peer_x_q;
  assign bus.seed_y_peer = peer_y_q;
  assign bus.peer_valid  = peer_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_seed_exchange.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seed_exchange : scoreboard bench for seed_exchange (BAUD_DIV = 8)     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+

module tb_seed_exchange;
  localparam int BAUD = 8;

  logic clk_75  = 1'b0;
  logic rst     = 1'b1;
  logic loop_en = 1'b0;
  logic rx_drv  = 1'b1;
  logic mon_en  = 1'b1;
  logic tx_prev_s = 1'b1;

  int n_tests  = 0;
  int n_fail   = 0;
  int pv_count = 0;

  logic [7:0] exp_tx[$];
  logic [9:0] exp_pair[$];

  seed_exchange_if ifc ();

  assign ifc.uart_rx = loop_en ? ifc.uart_tx : rx_drv;

  seed_exchange #(
    .BAUD_DIV (BAUD),
    .TAG_X    (3'b101),
    .TAG_Y    (3'b110)
  ) dut (
    .clk_75 (clk_75),
    .rst    (rst),
    .bus    (ifc.slave)
  );

  always #5 clk_75 = ~clk_75;

  // Decodes bytes leaving uart_tx and checks them against the expected queue
  initial begin : tx_mon
    logic [7:0] b;
    logic       stop_b;
    logic [7:0] e;
    forever begin
      @(negedge clk_75);
      if (tx_prev_s === 1'b1 && ifc.uart_tx === 1'b0) begin
        repeat (3) @(negedge clk_75);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk_75);
          b[i] = ifc.uart_tx;
        end
        repeat (BAUD) @(negedge clk_75);
        stop_b = ifc.uart_tx;
        if (mon_en) begin
          n_tests++;
          if (exp_tx.size() == 0) begin
            n_fail++;
            $display("FAIL tx_unexpected_byte: got 0x%02h, required no byte", b);
          end else begin
            e = exp_tx.pop_front();
            if (b !== e || stop_b !== 1'b1) begin
              n_fail++;
              $display("FAIL tx_byte: got 0x%02h stop=%b, required 0x%02h stop=1", b, stop_b, e);
            end
          end
        end
      end
      tx_prev_s = ifc.uart_tx;
    end
  end

  always @(negedge clk_75) begin : peer_mon
    logic [9:0] e;
    if (ifc.peer_valid === 1'b1) begin
      pv_count++;
      n_tests++;
      if (exp_pair.size() == 0) begin
        n_fail++;
        $display("FAIL peer_unexpected: got x=%0d y=%0d, required no commit",
                 ifc.seed_x_peer, ifc.seed_y_peer);
      end else begin
        e = exp_pair.pop_front();
        if ({ifc.seed_x_peer, ifc.seed_y_peer} !== e) begin
          n_fail++;
          $display("FAIL peer_pair: got x=%0d y=%0d, required x=%0d y=%0d",
                   ifc.seed_x_peer, ifc.seed_y_peer, e[9:5], e[4:0]);
        end
      end
    end
  end

  initial begin : watchdog
    repeat (100000) @(posedge clk_75);
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_75);
    rst = 1'b0;
    @(negedge clk_75);
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop_bit);
    rx_drv = 1'b0;
    repeat (BAUD) @(negedge clk_75);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (BAUD) @(negedge clk_75);
    end
    rx_drv = stop_bit;
    repeat (BAUD) @(negedge clk_75);
    rx_drv = 1'b1;
    if (!stop_bit) repeat (BAUD) @(negedge clk_75);
    repeat (2) @(negedge clk_75);
  endtask

  task automatic check_peer(input string name, input logic [4:0] x, input logic [4:0] y);
    n_tests++;
    if (ifc.seed_x_peer !== x || ifc.seed_y_peer !== y) begin
      n_fail++;
      $display("FAIL %s: got x=%0d y=%0d, required x=%0d y=%0d",
               name, ifc.seed_x_peer, ifc.seed_y_peer, x, y);
    end
  endtask

  task automatic check_pv(input string name, input int base, input int delta);
    n_tests++;
    if (pv_count - base !== delta) begin
      n_fail++;
      $display("FAIL %s: got %0d peer_valid pulses, required %0d", name, pv_count - base, delta);
    end
  endtask

  task automatic test_reset();
    ifc.seed_rdy     = 1'b0;
    ifc.seed_x_local = 5'd0;
    ifc.seed_y_local = 5'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk_75);
    n_tests += 3;
    if (ifc.uart_tx !== 1'b1) begin
      n_fail++; $display("FAIL reset_uart_tx: got %b, required 1", ifc.uart_tx);
    end
    if (ifc.tx_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_tx_busy: got %b, required 0", ifc.tx_busy);
    end
    if (ifc.peer_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_peer_valid: got %b, required 0", ifc.peer_valid);
    end
    check_peer("reset_peer", 5'd0, 5'd0);
    rst = 1'b0;
    @(negedge clk_75);
  endtask

  // Sends one local frame in loopback; optionally re-pulses seed_rdy mid-frame
  task automatic run_frame(input string name, input int repulse_at);
    int width;
    int pv0;
    loop_en = 1'b1;
    pv0 = pv_count;
    exp_tx.push_back(8'hA5);
    exp_tx.push_back(8'hD1);
    exp_pair.push_back({5'd5, 5'd17});
    ifc.seed_x_local = 5'd5;
    ifc.seed_y_local = 5'd17;
    ifc.seed_rdy     = 1'b1;
    @(negedge clk_75);
    ifc.seed_rdy = 1'b0;
    n_tests++;
    if (ifc.uart_tx !== 1'b0 || ifc.tx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_start: got uart_tx=%b tx_busy=%b, required 0 1", name, ifc.uart_tx, ifc.tx_busy);
    end
    width = 0;
    while (ifc.tx_busy === 1'b1 && width < 400) begin
      width++;
      if (width == repulse_at) begin
        ifc.seed_x_local = 5'd9;
        ifc.seed_rdy     = 1'b1;
      end else begin
        ifc.seed_rdy = 1'b0;
      end
      @(negedge clk_75);
    end
    ifc.seed_rdy = 1'b0;
    n_tests++;
    if (width != 160) begin
      n_fail++;
      $display("FAIL %s_busy_width: got %0d cycles, required 160", name, width);
    end
    repeat (40) @(negedge clk_75);
    n_tests++;
    if (exp_tx.size() != 0 || exp_pair.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d bytes %0d pairs pending, required 0 0",
               name, exp_tx.size(), exp_pair.size());
      exp_tx.delete();
      exp_pair.delete();
    end
    check_peer({name, "_peer"}, 5'd5, 5'd17);
    check_pv({name, "_pv"}, pv0, 1);
    loop_en = 1'b0;
  endtask

  task automatic test_loopback();
    run_frame("loopback", -1);
  endtask

  task automatic test_repulse();
    run_frame("repulse", 40);
  endtask

  task automatic test_orphan_y();
    int pv0;
    do_reset();
    pv0 = pv_count;
    rx_send(8'hD3, 1'b1);
    repeat (40) @(negedge clk_75);
    check_peer("orphan_y_peer", 5'd0, 5'd0);
    check_pv("orphan_y_pv", pv0, 0);
  endtask

  task automatic test_framing();
    int pv0;
    do_reset();
    pv0 = pv_count;
    rx_send(8'hA3, 1'b1);
    rx_send(8'hA5, 1'b0);
    rx_send(8'hD1, 1'b1);
    repeat (20) @(negedge clk_75);
    check_peer("framing_reject_peer", 5'd0, 5'd0);
    check_pv("framing_reject_pv", pv0, 0);
    exp_pair.push_back({5'd7, 5'd2});
    rx_send(8'hA7, 1'b1);
    rx_send(8'hC2, 1'b1);
    repeat (20) @(negedge clk_75);
    check_peer("framing_good_peer", 5'd7, 5'd2);
    check_pv("framing_good_pv", pv0, 1);
  endtask

  task automatic test_glitch();
    int pv0;
    pv0 = pv_count;
    rx_send(8'hA6, 1'b1);
    rx_drv = 1'b0;
    repeat (2) @(negedge clk_75);
    rx_drv = 1'b1;
    repeat (30) @(negedge clk_75);
    check_pv("glitch_no_byte_pv", pv0, 0);
    exp_pair.push_back({5'd6, 5'd4});
    rx_send(8'hC4, 1'b1);
    repeat (20) @(negedge clk_75);
    check_peer("glitch_keep_got_x", 5'd6, 5'd4);
    check_pv("glitch_pair_pv", pv0, 1);
  endtask

  task automatic test_reset_mid();
    int pv0;
    mon_en = 1'b0;
    loop_en = 1'b0;
    rx_send(8'hA8, 1'b1);
    pv0 = pv_count;
    fork
      rx_send(8'hC9, 1'b1);
      begin
        ifc.seed_x_local = 5'd12;
        ifc.seed_y_local = 5'd3;
        ifc.seed_rdy     = 1'b1;
        @(negedge clk_75);
        ifc.seed_rdy = 1'b0;
        repeat (30) @(negedge clk_75);
        rst = 1'b1;
        @(negedge clk_75);
        n_tests++;
        if (ifc.uart_tx !== 1'b1 || ifc.tx_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_mid_tx: got uart_tx=%b tx_busy=%b, required 1 0", ifc.uart_tx, ifc.tx_busy);
        end
        check_peer("reset_mid_peer", 5'd0, 5'd0);
        rst = 1'b0;
      end
    join
    repeat (120) @(negedge clk_75);
    check_peer("reset_mid_peer_after", 5'd0, 5'd0);
    check_pv("reset_mid_pv", pv0, 0);
  endtask

  initial begin : main
    test_reset();
    test_loopback();
    test_repulse();
    test_orphan_y();
    test_framing();
    test_glitch();
    test_reset_mid();
    n_tests++;
    if (exp_pair.size() != 0) begin
      n_fail++;
      $display("FAIL final_pairs_pending: got %0d, required 0", exp_pair.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
